// File: rtl/calculator_operand_alu.sv
// Operand/op holding registers plus add/sub (1 cycle), shift-add multiply and restoring divide (OPERAND_W cycles).
// No backpressure: loads and starts are ignored while busy. Divider present only when CALC_DIV_EN is defined.
module calculator_operand_alu #(
  parameter int OPERAND_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OPERAND_W-1:0]   switches,
  input  logic                   load_a_en,
  input  logic                   load_b_en,
  input  logic                   load_op_en,
  input  logic                   compute_req,
  output logic [OPERAND_W-1:0]   num_a,
  output logic [OPERAND_W-1:0]   num_b,
  output logic [1:0]             op,
  output logic [2*OPERAND_W-1:0] answer,
  output logic                   answer_valid,
  output logic                   busy,
  output logic                   error
);
  localparam int RW = 2 * OPERAND_W;
  localparam int CW = $clog2(OPERAND_W);
  localparam logic [CW-1:0] LAST_ITER = CW'(OPERAND_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [OPERAND_W-1:0]   num_a_q, num_a_d, num_b_q, num_b_d;
  logic [1:0]             op_q, op_d;
  logic [RW-1:0]          answer_q, answer_d;
  logic                   answer_valid_q, answer_valid_d;
  logic                   busy_q, busy_d;
  logic                   error_q, error_d;
  logic                   req_hist_q, req_hist_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          acc_q, acc_d, mcand_q, mcand_d;
  logic [OPERAND_W-1:0]   mplr_q, mplr_d;

  logic                   start, any_load;
  logic [OPERAND_W-1:0]   a_eff, b_eff;
  logic [1:0]             op_eff;
  logic [RW-1:0]          acc_nx;

  assign start    = compute_req & ~req_hist_q;
  assign any_load = load_a_en | load_b_en | load_op_en;
  assign a_eff    = load_a_en  ? switches      : num_a_q;
  assign b_eff    = load_b_en  ? switches      : num_b_q;
  assign op_eff   = load_op_en ? switches[1:0] : op_q;
  assign acc_nx   = mplr_q[0] ? acc_q + mcand_q : acc_q;

`ifdef CALC_DIV_EN
  logic [OPERAND_W-1:0]   rem_q, rem_d, quo_q, quo_d, rem_nx, quo_nx;
  logic [OPERAND_W:0]     trial;
  logic                   div_ge;

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign trial  = {rem_q, quo_q[OPERAND_W-1]};
  assign div_ge = trial >= {1'b0, num_b_q};
  assign rem_nx = div_ge ? OPERAND_W'(trial - {1'b0, num_b_q}) : trial[OPERAND_W-1:0];
  assign quo_nx = {quo_q[OPERAND_W-2:0], div_ge};
`endif

  always_comb begin
    state_d        = state_q;
    num_a_d        = num_a_q;
    num_b_d        = num_b_q;
    op_d           = op_q;
    answer_d       = answer_q;
    answer_valid_d = answer_valid_q;
    busy_d         = busy_q;
    error_d        = error_q;
    req_hist_d     = compute_req;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplr_d         = mplr_q;
`ifdef CALC_DIV_EN
    rem_d          = rem_q;
    quo_d          = quo_q;
`endif
    if (state_q != CALC) begin
      num_a_d = a_eff;
      num_b_d = b_eff;
      op_d    = op_eff;
      if (start) begin
        answer_valid_d = 1'b0;
        case (op_eff)
          2'b00: begin
            answer_d       = {{OPERAND_W{1'b0}}, a_eff} + {{OPERAND_W{1'b0}}, b_eff};
            error_d        = 1'b0;
            answer_valid_d = 1'b1;
            state_d        = DONE;
          end
          2'b01: begin
            answer_d       = {{OPERAND_W{1'b0}}, a_eff} - {{OPERAND_W{1'b0}}, b_eff};
            error_d        = 1'b0;
            answer_valid_d = 1'b1;
            state_d        = DONE;
          end
          2'b10: begin
            acc_d   = '0;
            mcand_d = {{OPERAND_W{1'b0}}, a_eff};
            mplr_d  = b_eff;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
          default: begin
`ifdef CALC_DIV_EN
            if (b_eff == '0) begin
              answer_d       = '1;
              error_d        = 1'b1;
              answer_valid_d = 1'b1;
              state_d        = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = a_eff;
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = CALC;
            end
`else
            answer_d       = '0;
            error_d        = 1'b1;
            answer_valid_d = 1'b1;
            state_d        = DONE;
`endif
          end
        endcase
      end else if (any_load && state_q == DONE) begin
        answer_valid_d = 1'b0;
        state_d        = IDLE;
      end
    end else begin
      cnt_d   = cnt_q + CW'(1);
      acc_d   = acc_nx;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
`ifdef CALC_DIV_EN
      rem_d   = rem_nx;
      quo_d   = quo_nx;
`endif
      if (cnt_q == LAST_ITER) begin
`ifdef CALC_DIV_EN
        answer_d = (op_q == 2'b11) ? {rem_nx, quo_nx} : acc_nx;
`else
        answer_d = acc_nx;
`endif
        error_d        = 1'b0;
        answer_valid_d = 1'b1;
        busy_d         = 1'b0;
        state_d        = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      num_a_q        <= '0;
      num_b_q        <= '0;
      op_q           <= '0;
      answer_q       <= '0;
      answer_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      req_hist_q     <= 1'b1;
      cnt_q          <= '0;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplr_q         <= '0;
`ifdef CALC_DIV_EN
      rem_q          <= '0;
      quo_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      num_a_q        <= num_a_d;
      num_b_q        <= num_b_d;
      op_q           <= op_d;
      answer_q       <= answer_d;
      answer_valid_q <= answer_valid_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      req_hist_q     <= req_hist_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplr_q         <= mplr_d;
`ifdef CALC_DIV_EN
      rem_q          <= rem_d;
      quo_q          <= quo_d;
`endif
    end
  end

  assign num_a        = num_a_q;
  assign num_b        = num_b_q;
  assign op           = op_q;
  assign answer       = answer_q;
  assign answer_valid = answer_valid_q;
  assign busy         = busy_q;
  assign error        = error_q;
endmodule
